// File: rtl/expr_sequencer.sv
// Moore control FSM that sequences the expression-solver datapath through
// S = (A*X + B)*X + C by Horner's rule, with start/busy/done handshake.
module expr_sequencer #(
    parameter bit OVF_ABORT = 1'b1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       zero,
    input  logic       overflow,
    output logic       busy,
    output logic       done,
    output logic       ovf_err,
    output logic       res_zero,
    output logic       LX,
    output logic       LS,
    output logic       LH,
    output logic       H,
    output logic [1:0] M0,
    output logic [1:0] M1,
    output logic [1:0] M2
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLR,
        S_MUL1,
        S_ADD1,
        S_MUL2,
        S_ADD2,
        S_DONE
    } state_t;

    state_t state_q, state_d;
    logic   ovf_err_q, ovf_err_d;
    logic   res_zero_q, res_zero_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            ovf_err_q  <= 1'b0;
            res_zero_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            ovf_err_q  <= ovf_err_d;
            res_zero_q <= res_zero_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        ovf_err_d  = ovf_err_q;
        res_zero_d = res_zero_q;
        busy       = 1'b1;
        done       = 1'b0;
        LX         = 1'b0;
        LS         = 1'b0;
        LH         = 1'b0;
        H          = 1'b0;
        M0         = 2'b00;
        M1         = 2'b00;
        M2         = 2'b00;

        case (state_q)
            S_IDLE: begin
                busy = 1'b0;
                if (start) begin
                    ovf_err_d  = 1'b0;
                    res_zero_d = 1'b0;
                    state_d    = S_CLR;
                end
            end
            S_CLR: begin
                LX      = 1'b1;
                LS      = 1'b1;
                M2      = 2'b01;
                state_d = S_MUL1;
            end
            S_MUL1: begin
                LS      = 1'b1;
                H       = 1'b1;
                M0      = 2'b01;
                M1      = 2'b01;
                M2      = 2'b01;
                state_d = S_ADD1;
            end
            S_ADD1: begin
                LS      = 1'b1;
                M0      = 2'b10;
                M1      = 2'b10;
                M2      = 2'b01;
                state_d = S_MUL2;
            end
            S_MUL2: begin
                LS      = 1'b1;
                H       = 1'b1;
                M1      = 2'b01;
                state_d = S_ADD2;
            end
            S_ADD2: begin
                LS      = 1'b1;
                M0      = 2'b11;
                M1      = 2'b10;
                M2      = 2'b01;
                state_d = S_DONE;
            end
            S_DONE: begin
                done       = 1'b1;
                res_zero_d = zero;
                state_d    = S_IDLE;
            end
            default: begin
                busy    = 1'b0;
                state_d = S_IDLE;
            end
        endcase

        // Only the four arithmetic steps can raise the error; S still loads that cycle.
        if ((state_q == S_MUL1 || state_q == S_ADD1 ||
             state_q == S_MUL2 || state_q == S_ADD2) && overflow) begin
            ovf_err_d = 1'b1;
            if (OVF_ABORT) state_d = S_DONE;
        end
    end

    assign ovf_err  = ovf_err_q;
    assign res_zero = res_zero_q;

endmodule

// File: tb/tb_expr_sequencer.sv
// Bench for expr_sequencer: two instances (abort / no-abort) each driving an
// emulated datapath, checked every cycle against a run-level reference model.
module tb_expr_sequencer;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [15:0] op_a = '0, op_b = '0, op_c = '0, op_x = '0;
    int          n_tests = 0;
    int          n_fail = 0;
    int          cyc = 0;
    bit          chk_en = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endfunction

    // expected {LX,LS,LH,H,M0,M1,M2} for each cycle of a run (1 = first busy cycle)
    function automatic logic [9:0] ctl_tbl(int p);
        case (p)
            1:       return 10'b1100_00_00_01;
            2:       return 10'b0101_01_01_01;
            3:       return 10'b0100_10_10_01;
            4:       return 10'b0101_00_01_00;
            5:       return 10'b0100_11_10_01;
            default: return 10'b0;
        endcase
    endfunction

    for (genvar G = 0; G < 2; G++) begin : g_dut
        localparam bit ABORT = (G == 0);
        logic        busy, done, ovf_err, res_zero, LX, LS, LH, H, zero, overflow;
        logic [1:0]  M0, M1, M2;
        logic [15:0] rx = '0, rs = '0, mux0, op1, op2;
        logic [31:0] alu;

        expr_sequencer #(.OVF_ABORT(ABORT)) dut (
            .clk(clk), .rst(rst), .start(start), .zero(zero), .overflow(overflow),
            .busy(busy), .done(done), .ovf_err(ovf_err), .res_zero(res_zero),
            .LX(LX), .LS(LS), .LH(LH), .H(H), .M0(M0), .M1(M1), .M2(M2)
        );

        // emulated operative block; Reg_H is never loaded so reads as zero
        always_comb begin
            case (M0)
                2'b00:   mux0 = 16'h0;
                2'b01:   mux0 = op_a;
                2'b10:   mux0 = op_b;
                default: mux0 = op_c;
            endcase
            case (M1)
                2'b00:   op1 = mux0;
                2'b01:   op1 = rx;
                2'b10:   op1 = rs;
                default: op1 = 16'h0;
            endcase
            case (M2)
                2'b00:   op2 = rs;
                2'b01:   op2 = mux0;
                default: op2 = 16'h0;
            endcase
            alu = H ? 32'(op1) * 32'(op2) : 32'(op1) + 32'(op2);
        end
        assign zero     = (rs == 16'h0);
        assign overflow = (alu[31:16] != 16'h0);

        always @(posedge clk) begin
            if (LX) rx <= op_x;
            if (LS) rs <= alu[15:0];
        end

        // run-level model: Horner steps precomputed at accept, then a phase count
        bit          m_active = 0, m_ovf = 0, m_rz = 0;
        int          m_phase = 0;
        logic [15:0] m_final = '0, s;
        logic [31:0] t;
        logic [15:0] s_after [2:5];
        bit          ovf_at  [2:5];
        int          st_cyc = 0, lat = 0, busy_cnt = 0, prev_done = 0, period = 0;

        always @(posedge clk) begin
            if (rst) begin
                m_active = 0; m_ovf = 0; m_rz = 0; m_phase = 0;
            end else if (!m_active) begin
                if (start) begin
                    t = 32'(op_a) * 32'(op_x); ovf_at[2] = t[31:16] != 0; s = t[15:0]; s_after[2] = s;
                    t = 32'(s) + 32'(op_b);    ovf_at[3] = t[31:16] != 0; s = t[15:0]; s_after[3] = s;
                    t = 32'(op_x) * 32'(s);    ovf_at[4] = t[31:16] != 0; s = t[15:0]; s_after[4] = s;
                    t = 32'(s) + 32'(op_c);    ovf_at[5] = t[31:16] != 0; s = t[15:0]; s_after[5] = s;
                    m_final = s_after[5];
                    if (ABORT)
                        for (int p = 5; p >= 2; p--) if (ovf_at[p]) m_final = s_after[p];
                    m_active = 1; m_phase = 1; m_ovf = 0; m_rz = 0;
                    st_cyc = cyc + 1; busy_cnt = 0;
                end
            end else if (m_phase == 6) begin
                m_active = 0;
                m_rz = (m_final == 16'h0);
            end else if (m_phase >= 2 && ovf_at[m_phase]) begin
                m_ovf = 1;
                m_phase = ABORT ? 6 : m_phase + 1;
            end else begin
                m_phase++;
            end
        end

        always @(negedge clk) begin
            if (chk_en) begin
                chk($sformatf("g%0d.busy", G), busy, m_active);
                chk($sformatf("g%0d.done", G), done, m_active && m_phase == 6);
                chk($sformatf("g%0d.ctl", G), {LX, LS, LH, H, M0, M1, M2},
                    m_active ? ctl_tbl(m_phase) : 10'b0);
                chk($sformatf("g%0d.ovf_err", G), ovf_err, m_ovf);
                chk($sformatf("g%0d.res_zero", G), res_zero, m_rz);
                if (busy) busy_cnt++;
                if (done) begin
                    lat = cyc - st_cyc + 1;
                    if (prev_done > 0) period = cyc - prev_done;
                    prev_done = cyc;
                    chk($sformatf("g%0d.result", G), rs, m_final);
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 30; i++) begin
            if (!g_dut[0].m_active && !g_dut[1].m_active) return;
            step();
        end
        n_tests++;
        n_fail++;
        $display("FAIL wait_idle: run did not finish within 30 cycles");
    endtask

    task automatic run(input logic [15:0] a, b, c, x);
        op_a = a; op_b = b; op_c = c; op_x = x;
        start = 1'b1;
        step();
        start = 1'b0;
        wait_idle();
        step();
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        step();
        chk_en = 1'b1;
        step();
        rst = 1'b0;
        chk("reset.busy0", g_dut[0].busy, 0);
        chk("reset.ctl1", {g_dut[1].LX, g_dut[1].LS, g_dut[1].H, g_dut[1].M0, g_dut[1].M1, g_dut[1].M2}, 0);

        // basic: (2*3+5)*3+7 = 40
        run(16'd2, 16'd5, 16'd7, 16'd3);
        chk("basic.lat0", g_dut[0].lat, 6);
        chk("basic.lat1", g_dut[1].lat, 6);
        chk("basic.result0", g_dut[0].rs, 40);
        chk("basic.model", g_dut[0].m_final, 40);
        chk("basic.res_zero", g_dut[0].res_zero, 0);
        chk("basic.ovf_err", g_dut[0].ovf_err, 0);
        chk("basic.busy_cycles", g_dut[0].busy_cnt, 6);

        run(16'd0, 16'd0, 16'd0, 16'd9);
        chk("zero.res_zero0", g_dut[0].res_zero, 1);
        chk("zero.res_zero1", g_dut[1].res_zero, 1);
        run(16'd0, 16'd0, 16'd1, 16'd9);
        chk("zero_c1.res_zero", g_dut[0].res_zero, 0);
        chk("zero_c1.result", g_dut[0].rs, 1);

        // 0x4000*8 overflows in the first multiply
        run(16'h4000, 16'd0, 16'd0, 16'd8);
        chk("ovf.lat_abort", g_dut[0].lat, 3);
        chk("ovf.lat_noabort", g_dut[1].lat, 6);
        chk("ovf.err_abort", g_dut[0].ovf_err, 1);
        chk("ovf.err_noabort", g_dut[1].ovf_err, 1);
        run(16'd1, 16'd1, 16'd1, 16'd2);
        chk("clean.err_abort", g_dut[0].ovf_err, 0);
        chk("clean.err_noabort", g_dut[1].ovf_err, 0);
        chk("clean.result1", g_dut[1].rs, 7);

        op_a = 16'd1; op_b = 16'd2; op_c = 16'd3; op_x = 16'd4;
        start = 1'b1;
        repeat (20) step();
        start = 1'b0;
        wait_idle();
        step();
        chk("hs.period0", g_dut[0].period, 7);
        chk("hs.period1", g_dut[1].period, 7);

        // reset while in the second multiply
        op_a = 16'd1; op_b = 16'd1; op_c = 16'd1; op_x = 16'd2;
        start = 1'b1;
        step();
        start = 1'b0;
        repeat (3) step();
        chk("midrst.in_mul2", {g_dut[0].H, g_dut[0].M1, g_dut[0].M2}, 5'b1_01_00);
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("midrst.busy", g_dut[0].busy, 0);
        chk("midrst.done", g_dut[1].done, 0);
        chk("midrst.ctl", {g_dut[0].LX, g_dut[0].LS, g_dut[0].H, g_dut[0].M0, g_dut[0].M1, g_dut[0].M2}, 0);
        step();
        run(16'd1, 16'd1, 16'd1, 16'd2);
        chk("midrst.rerun", g_dut[0].rs, 7);

        // random operands and start, including starts during busy
        for (int i = 0; i < 600; i++) begin
            if (!g_dut[0].m_active && !g_dut[1].m_active) begin
                if ($urandom_range(0, 3) == 0) begin
                    op_a = 16'($urandom); op_b = 16'($urandom);
                    op_c = 16'($urandom); op_x = 16'($urandom);
                end else begin
                    op_a = 16'($urandom_range(0, 15)); op_b = 16'($urandom_range(0, 15));
                    op_c = 16'($urandom_range(0, 3));  op_x = 16'($urandom_range(0, 15));
                end
            end
            start = ($urandom_range(0, 2) == 0);
            step();
        end
        start = 1'b0;
        wait_idle();
        step();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
